safe_game_ctrl: RTL

Round sequencer for the safe-cracking game: it latches a secret code from the free-running LFSR and gates digit editing. It also sequences each guess through the evaluator, records the correct/misplaced counts and counts attempts in two-digit BCD. It declares WIN or LOSE and sits between the key handlers, the digit editors, the evaluator and the marquee, replacing the ad-hoc attempt/lose logic in the top level.

---
 rtl/safe_pkg.sv | 25 ++
 rtl/safe_game_ctrl_tries.sv | 23 ++
 rtl/safe_game_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/safe_pkg.sv
// Shared types, sizes and the saturating BCD helper for the safe-cracking game.
package safe_pkg;

    localparam int DIGITS = 4;
    localparam int CODE_W = 2 * DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_PLAY = 3'd2,
        ST_EVAL = 3'd3,
        ST_WIN  = 3'd4,
        ST_LOSE = 3'd5
    } safe_state_t;

    // Two-digit BCD increment that sticks at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        if (v == 8'h99)
            return 8'h99;
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/safe_game_ctrl_tries.sv
// Two-digit BCD attempt counter with clear and saturation at 99.
module bcd_tries_counter
    import safe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clr)
            count_reg <= 8'h00;
        else if (inc)
            count_reg <= bcd_inc2(count_reg);
    end

    assign count = count_reg;

endmodule

// File: rtl/safe_game_ctrl.sv
// Round sequencer: latches the secret, gates editing, runs each guess through
// the evaluator and declares WIN or LOSE.
module safe_game_ctrl
    import safe_pkg::*;
#(
    parameter int MAX_TRIES = 99,
    parameter int EVAL_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              submit,
    input  logic [CODE_W-1:0] lfsr_q,
    input  logic [3:0]        n_correct,
    input  logic [3:0]        n_misplaced,
    output logic [CODE_W-1:0] code_out,
    output logic              edit_en,
    output logic [7:0]        tries,
    output logic [3:0]        res_correct,
    output logic [3:0]        res_misplaced,
    output logic              res_valid,
    output logic [2:0]        state_out,
    output logic              win,
    output logic              lose
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] ARM  = ST_ARM;
    localparam logic [2:0] PLAY = ST_PLAY;
    localparam logic [2:0] EVAL = ST_EVAL;
    localparam logic [2:0] WIN  = ST_WIN;
    localparam logic [2:0] LOSE = ST_LOSE;

    localparam logic [7:0] MAX_BCD = 8'(((MAX_TRIES / 10) * 16) + (MAX_TRIES % 10));
    localparam int WAIT_W = (EVAL_WAIT > 1) ? $clog2(EVAL_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EVAL_WAIT - 1);

    logic [2:0]        state_reg, state_next;
    logic [WAIT_W-1:0] eval_cnt_reg, eval_cnt_next;
    logic [CODE_W-1:0] code_reg;
    logic [3:0]        res_correct_reg, res_misplaced_reg;
    logic              res_valid_reg, edit_en_reg, win_reg, lose_reg;
    logic              arm_now, latch_now;
    logic [7:0]        tries_cnt, tries_inc_val;

    assign tries_inc_val = bcd_inc2(tries_cnt);

    always_comb begin
        state_next    = state_reg;
        eval_cnt_next = eval_cnt_reg;
        arm_now       = 1'b0;
        latch_now     = 1'b0;
        case (state_reg)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_next = ARM;
                    arm_now    = 1'b1;
                end
            end
            ARM: state_next = PLAY;
            PLAY: begin
                if (start) begin
                    state_next = ARM;
                    arm_now    = 1'b1;
                end else if (submit) begin
                    state_next    = EVAL;
                    eval_cnt_next = WAIT_LOAD;
                end
            end
            EVAL: begin
                if (eval_cnt_reg != '0) begin
                    eval_cnt_next = eval_cnt_reg - 1'b1;
                end else begin
                    latch_now = 1'b1;
                    // A correct guess wins even when it uses the last allowed try.
                    if (n_correct == 4'(DIGITS))
                        state_next = WIN;
                    else if (tries_inc_val == MAX_BCD)
                        state_next = LOSE;
                    else
                        state_next = PLAY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            eval_cnt_reg      <= '0;
            code_reg          <= '0;
            res_correct_reg   <= 4'd0;
            res_misplaced_reg <= 4'd0;
            res_valid_reg     <= 1'b0;
            edit_en_reg       <= 1'b0;
            win_reg           <= 1'b0;
            lose_reg          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            eval_cnt_reg  <= eval_cnt_next;
            res_valid_reg <= latch_now;
            edit_en_reg   <= (state_next == PLAY);
            win_reg       <= (state_next == WIN);
            lose_reg      <= (state_next == LOSE);
            if (arm_now) begin
                code_reg          <= lfsr_q;
                res_correct_reg   <= 4'd0;
                res_misplaced_reg <= 4'd0;
            end else if (latch_now) begin
                res_correct_reg   <= n_correct;
                res_misplaced_reg <= n_misplaced;
            end
        end
    end

    bcd_tries_counter u_tries (
        .clk   (clk),
        .reset (reset),
        .clr   (arm_now),
        .inc   (latch_now),
        .count (tries_cnt)
    );

    assign code_out      = code_reg;
    assign edit_en       = edit_en_reg;
    assign tries         = tries_cnt;
    assign res_correct   = res_correct_reg;
    assign res_misplaced = res_misplaced_reg;
    assign res_valid     = res_valid_reg;
    assign state_out     = state_reg;
    assign win           = win_reg;
    assign lose          = lose_reg;

endmodule
